// File: rtl/riscv_ex_muldiv_pkg.sv
// Shared funct3 encodings and decode helpers for the EX-stage multiply/divide unit.
package riscv_ex_muldiv_pkg;

  localparam logic [2:0] FUNCT3_MULDIV_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULDIV_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_MULDIV_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_MULDIV_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_MULDIV_REMU   = 3'b111;

  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] f);
    return (f == FUNCT3_MULDIV_MULH) || (f == FUNCT3_MULDIV_MULHSU) ||
           (f == FUNCT3_MULDIV_DIV)  || (f == FUNCT3_MULDIV_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == FUNCT3_MULDIV_MULH) || (f == FUNCT3_MULDIV_DIV) ||
           (f == FUNCT3_MULDIV_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One combinational radix-2 step: shift-add multiply or restoring shift-subtract divide.
module riscv_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb} : '0);
    div_shift = {hi_in, lo_in[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (div_mode) begin
      // Top bit of the difference is the borrow: set means the divisor did not fit.
      if (!div_diff[XLEN]) begin
        hi_out = div_diff[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = div_shift[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_out = mul_sum[XLEN:1];
      lo_out = {mul_sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit; stalls EX while computing, then
// presents a registered result for one cycle.
module riscv_ex_muldiv #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);
  import riscv_ex_muldiv_pkg::*;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned    Steps   = XLEN / UNROLL;
  localparam int unsigned    CntW    = $clog2(Steps);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] count_q;
  logic [2:0]      funct3_q;
  logic            neg_a_q, neg_b_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q, result_q;

  logic            accept, calc_last;
  logic            neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_result, final_result;
  logic [2*XLEN-1:0] prod, prod_fix;

  logic [XLEN-1:0] hi_c [UNROLL+1];
  logic [XLEN-1:0] lo_c [UNROLL+1];

  assign accept    = (state_q == StIdle) && i_valid && !i_flush;
  assign calc_last = (state_q == StCalc) && (count_q == LastCnt);

  // Operand magnitudes and early-out detection at accept time.
  always_comb begin
    neg_a    = rs1_signed(i_funct3) && i_rs1_data[XLEN-1];
    neg_b    = rs2_signed(i_funct3) && i_rs2_data[XLEN-1];
    mag_a    = neg_a ? -i_rs1_data : i_rs1_data;
    mag_b    = neg_b ? -i_rs2_data : i_rs2_data;
    div_zero = is_div_op(i_funct3) && (i_rs2_data == '0);
    div_ovf  = is_div_op(i_funct3) && !i_funct3[0] &&
               (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_data == '1);
    special_result = '0;
    if (div_zero) begin
      special_result = i_funct3[1] ? i_rs1_data : '1;
    end else if (div_ovf) begin
      special_result = i_funct3[1] ? '0 : i_rs1_data;
    end
  end

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    riscv_muldiv_step #(
      .XLEN(XLEN)
    ) u_step (
      .div_mode(is_div_op(funct3_q)),
      .hi_in   (hi_c[g]),
      .lo_in   (lo_c[g]),
      .opb     (opb_q),
      .hi_out  (hi_c[g+1]),
      .lo_out  (lo_c[g+1])
    );
  end

  // Sign fix-up on the final step outputs; lo holds the quotient, hi the remainder.
  always_comb begin
    prod     = {hi_c[UNROLL], lo_c[UNROLL]};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    unique case (funct3_q)
      FUNCT3_MULDIV_MUL:    final_result = prod_fix[XLEN-1:0];
      FUNCT3_MULDIV_MULH,
      FUNCT3_MULDIV_MULHSU,
      FUNCT3_MULDIV_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
      FUNCT3_MULDIV_DIV,
      FUNCT3_MULDIV_DIVU:   final_result = (neg_a_q ^ neg_b_q) ? -lo_c[UNROLL] : lo_c[UNROLL];
      default:              final_result = neg_a_q ? -hi_c[UNROLL] : hi_c[UNROLL];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (i_valid) state_d = (div_zero || div_ovf) ? StDone : StCalc;
        StCalc: if (count_q == LastCnt) state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_stall = accept || (state_q == StCalc);
    o_valid = (state_q == StDone);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= '0;
      funct3_q <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (!i_flush) begin
      if (accept) begin
        count_q  <= '0;
        funct3_q <= i_funct3;
        neg_a_q  <= neg_a;
        neg_b_q  <= neg_b;
        hi_q     <= '0;
        lo_q     <= is_div_op(i_funct3) ? mag_a : mag_b;
        opb_q    <= is_div_op(i_funct3) ? mag_b : mag_a;
        if (div_zero || div_ovf) result_q <= special_result;
      end else if (state_q == StCalc) begin
        hi_q    <= hi_c[UNROLL];
        lo_q    <= lo_c[UNROLL];
        count_q <= count_q + CntW'(1);
        if (calc_last) result_q <= final_result;
      end
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_riscv_ex_muldiv.sv
// Scoreboard bench: drivers push expected result/cycle, monitors pop on o_valid.
module tb_riscv_ex_muldiv;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic        v32 = 0, fl32 = 0, st32, ov32;
  logic [2:0]  f32 = '0;
  logic [31:0] a32 = '0, b32 = '0, r32;
  logic        v4 = 0, fl4 = 0, st4, ov4;
  logic [2:0]  f4 = '0;
  logic [31:0] a4 = '0, b4 = '0, r4;

  exp_t q32[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_ex_muldiv #(.XLEN(32), .UNROLL(1)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(v32), .i_flush(fl32), .i_funct3(f32),
    .i_rs1_data(a32), .i_rs2_data(b32), .o_stall(st32), .o_valid(ov32), .o_result(r32)
  );

  riscv_ex_muldiv #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_flush(fl4), .i_funct3(f4),
    .i_rs1_data(a4), .i_rs2_data(b4), .o_stall(st4), .o_valid(ov4), .o_result(r4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every o_valid must match the oldest expected entry, value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ov32) begin
      n_tests++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL mon32_unexpected: got %h at cycle %0d, expected no o_valid", r32, cyc);
      end else begin
        e = q32.pop_front();
        if (r32 !== e.res || cyc != int'(e.at)) begin
          n_fail++;
          $display("FAIL mon32: got %h at cycle %0d, expected %h at cycle %0d",
                   r32, cyc, e.res, e.at);
        end
      end
    end
    if (ov4) begin
      n_tests++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL mon4_unexpected: got %h at cycle %0d, expected no o_valid", r4, cyc);
      end else begin
        e = q4.pop_front();
        if (r4 !== e.res || cyc != int'(e.at)) begin
          n_fail++;
          $display("FAIL mon4: got %h at cycle %0d, expected %h at cycle %0d",
                   r4, cyc, e.res, e.at);
        end
      end
    end
  end

  task automatic start_op(input bit sel, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit push);
    exp_t e;
    e.res = exp;
    e.at  = 32'(cyc + lat);
    if (sel) begin
      v4 = 1; fl4 = 0; f4 = f; a4 = a; b4 = b;
      if (push) q4.push_back(e);
    end else begin
      v32 = 1; fl32 = 0; f32 = f; a32 = a; b32 = b;
      if (push) q32.push_back(e);
    end
  endtask

  // Pipeline-like: i_valid stays high while stalled and through the DONE cycle.
  task automatic follow_op(input bit sel, input int lat, input string name);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check({name, "_stall"}, {31'd0, sel ? st4 : st32}, {31'd0, k < lat});
      if (k < lat) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_op(input bit sel, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input string name);
    @(posedge clk);
    #1;
    start_op(sel, f, a, b, exp, lat, 1'b1);
    follow_op(sel, lat, name);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_result32", r32, 32'h0);
    check("rst_valid32", {31'd0, ov32}, 32'h0);
    check("rst_stall32", {31'd0, st32}, 32'h0);
    check("rst_result4", r4, 32'h0);
    rst = 0;

    run_op(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run_op(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    run_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
    run_op(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div");
    run_op(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem");
    run_op(0, 3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, "divu");
    run_op(0, 3'b111, 32'd7,        32'hFFFFFFFF, 32'd7,        33, "remu");
    run_op(0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_zero");
    run_op(0, 3'b110, 32'd5,        32'd0,        32'd5,        1,  "rem_zero");
    run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");
    run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");

    // Flush at T+10, new MUL accepted at T+11.
    @(posedge clk);
    #1;
    start_op(0, 3'b000, 32'h12345, 32'h777, 32'd0, 0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    fl32 = 1;
    @(posedge clk);
    #1;
    start_op(0, 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b1);
    check("flush_keep_result", r32, 32'h80000000);
    check("flush_no_valid", {31'd0, ov32}, 32'h0);
    follow_op(0, 33, "mul_after_flush");

    // Reset at T+5 mid-CALC.
    @(posedge clk);
    #1;
    start_op(0, 3'b000, 32'd5, 32'd6, 32'd0, 0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    v32 = 0;
    @(posedge clk);
    #1;
    check("midrst_result", r32, 32'h0);
    check("midrst_valid", {31'd0, ov32}, 32'h0);
    check("midrst_stall", {31'd0, st32}, 32'h0);
    rst = 0;

    run_op(1, 3'b101, 32'd100, 32'd7, 32'd14, 9, "u4_divu");
    run_op(1, 3'b111, 32'd100, 32'd7, 32'd2,  9, "u4_remu");
    @(posedge clk);
    #1;
    v4 = 0;

    repeat (4) @(posedge clk);
    #1;
    check("q32_drained", 32'(q32.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
